cdc_handshake_tx: RTL and testbench

Source side of a 2-phase (toggle) request/acknowledge handshake that carries a data word to a receiver in an unrelated clock domain. It accepts words locally with a valid/ready handshake, holds each word stable on XferData, and toggles XferReq. It then waits for the receiver's XferAck toggle, which it synchronizes internally before accepting the next word. It sits at the transmitting end of every multi-bit clock-domain crossing in the design.

---
 rtl/cdc_handshake_tx_pkg.sv | 13 +
 rtl/cdc_handshake_tx_sync_rst.sv | 24 ++
 rtl/cdc_handshake_tx.sv | 85 ++++++++
 tb/tb_cdc_handshake_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_handshake_tx_pkg.sv
// cdc_handshake_tx_pkg: state encoding and counter-width helper shared by the
// toggle-handshake transmitter (and its matching receiver).
package cdc_handshake_tx_pkg;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_ACK = 1'b1;

    // Width of a counter that must hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cdc_handshake_tx_sync_rst.sv
// cdc_sync_rst: multi-flop synchronizer for a single level crossing into clk.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage to 0
//   d     - asynchronous input level
//   q     - synchronized level (final stage)
module cdc_sync_rst #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a 2-phase (toggle) req/ack crossing.
//   Clk, ResetN       - clock, asynchronous active-low reset
//   InData/InValid    - local word offered for transfer
//   InReady           - high while idle (word can be accepted)
//   XferData/XferReq  - registered word and request level to the receiver
//   XferAck           - asynchronous ack level returned by the receiver
//   Done              - one-cycle pulse when a transfer completes
//   Timeout           - one-cycle pulse each time the ack wait expires
module cdc_handshake_tx
    import cdc_handshake_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic [DATA_WIDTH-1:0] InData,
    input  logic                  InValid,
    output logic                  InReady,
    output logic [DATA_WIDTH-1:0] XferData,
    output logic                  XferReq,
    input  logic                  XferAck,
    output logic                  Done,
    output logic                  Timeout
);

    logic [0:0] state;
    logic       ack_sync;
    logic       waiting;
    logic       matched;

    cdc_sync_rst #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (Clk),
        .rst_n (ResetN),
        .d     (XferAck),
        .q     (ack_sync)
    );

    assign waiting = state == ST_WAIT_ACK;
    // Ack phase catching up with the request phase means the receiver has taken the word.
    assign matched = waiting && (ack_sync == XferReq);
    assign InReady = !waiting;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state    <= ST_IDLE;
            XferReq  <= 1'b0;
            XferData <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= matched;
            if (matched) begin
                state <= ST_IDLE;
            end else if (InValid && InReady) begin
                XferData <= InData;
                XferReq  <= ~XferReq;
                state    <= ST_WAIT_ACK;
            end
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int            CW   = cnt_width(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            logic [CW-1:0] cnt;
            logic          expire;
            // Completion takes priority over an expiry landing on the same edge.
            assign expire = waiting && !matched && (cnt == LAST);
            always_ff @(posedge Clk or negedge ResetN) begin
                if (!ResetN) begin
                    cnt     <= '0;
                    Timeout <= 1'b0;
                end else begin
                    Timeout <= expire;
                    cnt     <= (!waiting || expire) ? '0 : cnt + CW'(1);
                end
            end
        end else begin : g_no_timeout
            assign Timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed and randomized checks of the toggle-handshake transmitter.
module tb_cdc_handshake_tx;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int TO   = 5;

    logic          Clk     = 1'b0;
    logic          ResetN  = 1'b0;
    logic          InValid = 1'b0;
    logic          XferAck = 1'b0;
    logic [DW-1:0] InData  = '0;
    logic          InReady, XferReq, Done, Timeout;
    logic [DW-1:0] XferData;

    int checks = 0;
    int errors = 0;
    int rx_mode = 0;
    int rx_delay = 0;
    int rx_count = 0;
    int acc_count = 0;

    logic          m_busy, m_req, m_done, m_to, m_sync;
    logic [DW-1:0] m_data;
    int            m_since;
    logic          ackq [SYNC];
    logic [DW-1:0] exp_q [$];

    always #5 Clk = ~Clk;

    cdc_handshake_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .InData   (InData),
        .InValid  (InValid),
        .InReady  (InReady),
        .XferData (XferData),
        .XferReq  (XferReq),
        .XferAck  (XferAck),
        .Done     (Done),
        .Timeout  (Timeout)
    );

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle(input int n);
        int k = 0;
        while (!InReady && k < n) begin
            tick();
            k++;
        end
        checks++;
        if (!InReady) begin
            errors++;
            $display("FAIL wait_idle: in_ready still %b after %0d cycles", InReady, n);
        end
    endtask

    // Behavioural model: the ack is seen SYNC edges after it is sampled; a transfer
    // ends on the first edge where that delayed ack equals the request phase, and
    // otherwise a timeout fires every TO edges of waiting.
    always @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            m_busy  = 1'b0;
            m_req   = 1'b0;
            m_data  = '0;
            m_done  = 1'b0;
            m_to    = 1'b0;
            m_since = 0;
            foreach (ackq[i]) ackq[i] = 1'b0;
        end else begin
            m_sync = ackq[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) ackq[i] = ackq[i-1];
            ackq[0] = XferAck;
            m_done = 1'b0;
            m_to   = 1'b0;
            if (m_busy) begin
                m_since++;
                if (m_sync == m_req) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else if (m_since == TO) begin
                    m_to    = 1'b1;
                    m_since = 0;
                end
            end else if (InValid) begin
                m_busy  = 1'b1;
                m_req   = ~m_req;
                m_data  = InData;
                m_since = 0;
                acc_count++;
                if (rx_mode == 2) exp_q.push_back(InData);
            end
        end
    end

    always @(negedge Clk) begin
        chk_bit("in_ready", InReady, !m_busy);
        chk_bit("xfer_req", XferReq, m_req);
        chk_vec("xfer_data", 32'(XferData), 32'(m_data));
        chk_bit("done", Done, m_done);
        chk_bit("timeout", Timeout, m_to);
    end

    // Receiver: mode 1 acks immediately, mode 2 after a random delay and scoreboards the word.
    always @(posedge Clk) begin
        #1;
        if (ResetN && rx_mode == 1) begin
            XferAck = XferReq;
        end else if (ResetN && rx_mode == 2 && XferReq !== XferAck) begin
            if (rx_delay > 0) begin
                rx_delay--;
            end else begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_word: got %0h with no word outstanding", XferData);
                end else begin
                    chk_vec("rx_word", 32'(XferData), 32'(exp_q.pop_front()));
                end
                XferAck  = XferReq;
                rx_delay = $urandom_range(0, 20);
            end
        end
    end

    initial begin
        // 1: reset
        repeat (3) tick();
        ResetN = 1'b1;
        tick();
        chk_bit("t1_in_ready", InReady, 1'b1);
        chk_bit("t1_req", XferReq, 1'b0);
        chk_vec("t1_data", 32'(XferData), 32'h0);
        chk_bit("t1_done", Done, 1'b0);
        chk_bit("t1_timeout", Timeout, 1'b0);

        // 2: ideal receiver, back-to-back words
        rx_mode = 1;
        InData  = 8'hA5;
        InValid = 1'b1;
        tick();
        chk_vec("t2_data", 32'(XferData), 32'hA5);
        chk_bit("t2_req", XferReq, 1'b1);
        chk_bit("t2_ready0", InReady, 1'b0);
        InData = 8'h3C;
        tick();
        chk_bit("t2_ready1", InReady, 1'b0);
        tick();
        chk_bit("t2_ready2", InReady, 1'b0);
        chk_bit("t2_done_early", Done, 1'b0);
        tick();
        chk_bit("t2_done", Done, 1'b1);
        chk_bit("t2_ready3", InReady, 1'b1);
        tick();
        chk_bit("t2_req2", XferReq, 1'b0);
        chk_vec("t2_data2", 32'(XferData), 32'h3C);
        chk_bit("t2_done_once", Done, 1'b0);
        InValid = 1'b0;
        wait_idle(20);

        // 3: ack held, periodic timeouts, then late ack
        rx_mode = 0;
        InData  = 8'h77;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        InData  = 8'hFF;
        chk_bit("t3_req", XferReq, 1'b1);
        for (int j = 1; j <= 16; j++) begin
            tick();
            chk_bit("t3_timeout", Timeout, (j % 5 == 0));
            chk_bit("t3_ready", InReady, 1'b0);
            chk_vec("t3_data", 32'(XferData), 32'h77);
        end
        XferAck = 1'b1;
        tick();
        chk_bit("t3_done_e1", Done, 1'b0);
        tick();
        chk_bit("t3_done_e2", Done, 1'b0);
        tick();
        chk_bit("t3_done", Done, 1'b1);
        chk_bit("t3_to_at_done", Timeout, 1'b0);
        chk_bit("t3_ready_end", InReady, 1'b1);

        // 4: ack match coincides with timeout expiry
        InData  = 8'h99;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        chk_bit("t4_req", XferReq, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            if (j == 2) XferAck = 1'b0;
            chk_bit("t4_done_early", Done, 1'b0);
            chk_bit("t4_to_early", Timeout, 1'b0);
        end
        tick();
        chk_bit("t4_done", Done, 1'b1);
        chk_bit("t4_to", Timeout, 1'b0);
        chk_bit("t4_ready", InReady, 1'b1);

        // 5: reset mid-transfer
        InData  = 8'h55;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        chk_bit("t5_req_pre", XferReq, 1'b1);
        chk_vec("t5_data_pre", 32'(XferData), 32'h55);
        tick();
        #2 ResetN = 1'b0;
        #1;
        chk_bit("t5_req", XferReq, 1'b0);
        chk_vec("t5_data", 32'(XferData), 32'h0);
        chk_bit("t5_ready", InReady, 1'b1);
        XferAck = 1'b0;
        repeat (2) tick();
        ResetN = 1'b1;
        repeat (4) begin
            tick();
            chk_bit("t5_no_done", Done, 1'b0);
        end

        // 6: random traffic with a delayed receiver
        acc_count = 0;
        rx_count  = 0;
        exp_q.delete();
        rx_delay  = $urandom_range(0, 20);
        rx_mode   = 2;
        for (int cyc = 0; cyc < 40000 && acc_count < 1000; cyc++) begin
            InValid = 1'($urandom_range(0, 1));
            InData  = DW'($urandom);
            tick();
        end
        InValid = 1'b0;
        chk_vec("t6_accepted", acc_count, 1000);
        for (int k = 0; k < 100 && !(rx_count == acc_count && InReady); k++) tick();
        chk_vec("t6_rx_count", rx_count, 1000);
        chk_vec("t6_queue_empty", exp_q.size(), 0);
        chk_bit("t6_idle", InReady, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
